ex_alu_muldiv: RTL

//  Execute-stage ALU directly downstream of the ALU control decoder; consumes its 4-bit ALU_Control code.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_seq.sv | 159 +++++++++++++++
 rtl/ex_alu_muldiv.sv | 61 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes and the multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] code);
    return (code == ALU_MULT) || (code == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply (shift/add) and divide (restoring shift/subtract) on magnitudes,
// with a final sign-fixup cycle that writes Hi/Lo and pulses Done.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, rem_shift, rem_trial;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quot, rem;

  // acc holds the running high half (mult) or partial remainder (div); work holds the low half / quotient.
  always_comb begin
    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b[WIDTH-1] ? -b : b;
    add_sum   = acc_q + (work_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, opb_q};
    prod_mag  = {acc_q[WIDTH-1:0], work_q};
    prod      = neg_res_q ? -prod_mag : prod_mag;
    quot      = dz_q ? {WIDTH{1'b1}} : (neg_res_q ? -work_q : work_q);
    rem       = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && is_muldiv(alu_control)) begin
          state_d   = RUN;
          cnt_d     = CW'(ITERS - 1);
          is_div_d  = (alu_control == ALU_DIV);
          neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          dz_d      = (b == '0);
          acc_d     = '0;
          work_d    = a_mag;
          opb_d     = b_mag;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!rem_trial[WIDTH]) begin
            acc_d  = rem_trial;
            work_d = {work_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = rem_shift;
            work_d = {work_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d  = {1'b0, add_sum[WIDTH:1]};
          work_d = {add_sum[0], work_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush squashes whatever is in flight, including a same-cycle start, and leaves Hi/Lo alone.
    if (flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_q     <= '0;
      work_q    <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE) | (start & is_muldiv(alu_control));
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops plus a sequential multiply/divide unit
// that owns Hi/Lo and requests stalls through Busy.
module ex_alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Shamt,
  input  logic             Start,
  input  logic             Flush,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  always_comb begin
    ALU_Result = '0;
    unique case (ALU_Control)
      ALU_AND: ALU_Result = A & B;
      ALU_OR:  ALU_Result = A | B;
      ALU_ADD: ALU_Result = A + B;
      ALU_XOR: ALU_Result = A ^ B;
      ALU_SUB: ALU_Result = A - B;
      ALU_SLT: ALU_Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLL: ALU_Result = B << Shamt;
      ALU_SRL: ALU_Result = B >> Shamt;
      ALU_SRA: ALU_Result = WIDTH'($signed(B) >>> Shamt);
      ALU_NOR: ALU_Result = ~(A | B);
      default: ALU_Result = '0;
    endcase
  end

  assign Zero = (ALU_Result == '0);

  muldiv_seq #(
    .WIDTH(WIDTH),
    .ITERS(ITERS)
  ) u_muldiv (
    .clk        (Clk),
    .srst       (Reset),
    .start      (Start),
    .flush      (Flush),
    .alu_control(ALU_Control),
    .a          (A),
    .b          (B),
    .busy       (Busy),
    .done       (Done),
    .hi         (Hi),
    .lo         (Lo)
  );

endmodule
